// File: rtl/gate_alu.sv
// gate_alu: registered WIDTH-bit bitwise logic unit with a one-entry output
// buffer, an optional accumulator operand, and a saturating accept counter.
module gate_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_XOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] result;
    logic             accept;

    // The output buffer can take a new result when empty or being drained
    // this cycle, which gives full throughput while out_ready stays high.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand select and the fully decoded bitwise operation.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        result = '0;
        a_eff  = acc_en ? acc_q : a;
        case (op_e'(op))
            OP_AND:    result = a_eff & b;
            OP_OR:     result = a_eff | b;
            OP_NOR:    result = ~(a_eff | b);
            OP_NAND:   result = ~(a_eff & b);
            OP_XOR:    result = a_eff ^ b;
            OP_XNOR:   result = ~(a_eff ^ b);
            OP_NOT_A:  result = ~a_eff;
            OP_PASS_B: result = b;
            default:   result = '0;
        endcase
    end

    // Output register: y/zero/parity load only on accept and otherwise hold,
    // so a stalled result stays stable until the consumer takes it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= result;
            zero      <= (result == '0);
            parity    <= ^result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: clear wins over a same-cycle accept, but the result of
    // that accept was already computed from the old value above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= result;
        end
    end

    // Accepted-transaction counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gate_alu.sv
// tb_gate_alu: directed tables, hand sequences and randomized traffic for
// gate_alu, checked against a truth-table reference model.
module tb_gate_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_en;
    logic       acc_clr;
    logic       out_ready;

    logic        in_ready, out_valid, zero, parity;
    logic [7:0]  y;
    logic [15:0] count;

    logic        sat_in_ready, sat_out_valid, sat_zero, sat_parity;
    logic [7:0]  sat_y;
    logic [1:0]  sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0]  m_acc;
    logic [7:0]  m_y;
    logic        m_valid;
    int          m_cnt;
    int          m_scnt;

    always #5 clk = ~clk;

    gate_alu #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
        .parity(parity), .count(count)
    );

    gate_alu #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(sat_out_valid), .out_ready(out_ready), .y(sat_y), .zero(sat_zero),
        .parity(sat_parity), .count(sat_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Each opcode as a 2-input gate truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_op(input logic [2:0] f, input logic [7:0] x, input logic [7:0] z);
        logic [3:0] tt [8];
        logic [3:0] t;
        logic [7:0] r;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0001; tt[3] = 4'b0111;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1010;
        t = tt[f];
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = t[{x[i], z[i]}];
        return r;
    endfunction

    function automatic logic ref_par(input logic [7:0] v);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(v[i]);
        return logic'(ones % 2);
    endfunction

    task automatic set_in(input logic v, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] z, input logic ae, input logic ac, input logic r);
        in_valid = v; op = o; a = x; b = z; acc_en = ae; acc_clr = ac; out_ready = r;
    endtask

    // Applies current inputs for one clock edge, steps the model, compares.
    task automatic cycle();
        logic       m_ready;
        logic [7:0] res;
        #1;
        m_ready = !m_valid || out_ready;
        check("in_ready", in_ready, m_ready);
        if (in_valid && m_ready) begin
            res     = ref_op(op, acc_en ? m_acc : a, b);
            m_y     = res;
            m_valid = 1'b1;
            m_acc   = res;
            if (m_cnt < 65535) m_cnt++;
            if (m_scnt < 3) m_scnt++;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (acc_clr) m_acc = '0;
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("y", y, m_y);
        check("zero", zero, m_y == 8'h00);
        check("parity", parity, ref_par(m_y));
        check("count", count, m_cnt);
        check("sat_count", sat_count, m_scnt);
        check("sat_y", sat_y, m_y);
        check("sat_out_valid", sat_out_valid, m_valid);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_y"}, y, 8'h00);
        check({tag, "_zero"}, zero, 1'b1);
        check({tag, "_parity"}, parity, 1'b0);
        check({tag, "_count"}, count, 16'd0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    // Asserts reset between edges, checks it took effect before any edge,
    // then releases it just after an edge.
    task automatic do_reset(input string tag);
        set_in(0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        m_acc = '0; m_y = '0; m_valid = 0; m_cnt = 0; m_scnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] y;
        logic       par;
    } sweep_t;

    sweep_t sweep [8];

    initial begin
        // a=0xCA, b=0x5C through all opcodes
        sweep[0] = '{3'd0, 8'h48, 1'b0};
        sweep[1] = '{3'd1, 8'hDE, 1'b0};
        sweep[2] = '{3'd2, 8'h21, 1'b0};
        sweep[3] = '{3'd3, 8'hB7, 1'b0};
        sweep[4] = '{3'd4, 8'h96, 1'b0};
        sweep[5] = '{3'd5, 8'h69, 1'b0};
        sweep[6] = '{3'd6, 8'h35, 1'b0};
        sweep[7] = '{3'd7, 8'h5C, 1'b0};

        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1);
        #2;
        do_reset("rst");

        // Opcode sweep, one accept per cycle
        foreach (sweep[i]) begin
            set_in(1, sweep[i].op, 8'hCA, 8'h5C, 0, 0, 1);
            cycle();
            check($sformatf("sweep_y_op%0d", i), y, sweep[i].y);
            check($sformatf("sweep_par_op%0d", i), parity, sweep[i].par);
        end
        check("sweep_count", count, 16'd8);

        // Backpressure
        do_reset("rst2");
        set_in(1, 3'd0, 8'hFF, 8'h0F, 0, 0, 0);
        cycle();
        check("bp_first_y", y, 8'h0F);
        set_in(1, 3'd1, 8'h30, 8'h03, 0, 0, 0);
        repeat (3) begin
            cycle();
            check("bp_hold_y", y, 8'h0F);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_count", count, 16'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_y", y, 8'h33);
        check("bp_release_count", count, 16'd2);

        // Accumulator chaining
        set_in(0, 3'd0, 8'h00, 8'h00, 0, 1, 1);
        cycle();
        set_in(1, 3'd4, 8'h00, 8'h11, 0, 0, 1);
        cycle();
        check("acc_xor_y", y, 8'h11);
        set_in(1, 3'd4, 8'hAA, 8'h11, 1, 0, 1);
        cycle();
        check("acc_chain_y", y, 8'h00);
        check("acc_chain_zero", zero, 1'b1);
        set_in(1, 3'd1, 8'h55, 8'hF0, 1, 0, 1);
        cycle();
        check("acc_or_y", y, 8'hF0);

        // Clear colliding with an accept
        set_in(1, 3'd1, 8'h00, 8'h01, 1, 1, 1);
        cycle();
        check("clr_coll_y", y, 8'hF1);
        set_in(1, 3'd1, 8'h00, 8'h02, 1, 0, 1);
        cycle();
        check("clr_after_y", y, 8'h02);

        // Counter saturation on the CNT_W=2 instance
        do_reset("rst3");
        for (int i = 0; i < 5; i++) begin
            set_in(1, 3'd7, 8'h00, 8'(i + 1), 0, 0, 1);
            cycle();
            check($sformatf("sat_cnt_%0d", i), sat_count, (i < 3) ? i + 1 : 3);
            check($sformatf("sat_valid_%0d", i), sat_out_valid, 1'b1);
            check($sformatf("sat_y_%0d", i), sat_y, i + 1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(logic'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) == 0),
                   logic'($urandom_range(0, 9) < 7));
            cycle();
        end

        // Asynchronous reset mid-stream, with a result pending
        set_in(1, 3'd7, 8'h00, 8'h81, 0, 0, 0);
        cycle();
        #2;
        do_reset("async_rst");
        set_in(1, 3'd6, 8'h0F, 8'h00, 0, 0, 1);
        cycle();
        check("post_rst_y", y, 8'hF0);
        check("post_rst_count", count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
